button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Sits directly downstream of the two-flop signal synchroniser; consumes its already-synchronised push-button level.
- Produces a clean debounced level plus single-cycle press, release and auto-repeat strobes for the control logic.
- Debounces with a counter-based FSM and optionally generates typematic repeat pulses while the button is held.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive identical samples required to accept a level change; must be >= 1.
- HOLD_CYCLES, 50000000: cycles in the held state before the first repeat pulse; must be >= 1.
- REPEAT_CYCLES, 10000000: cycles between subsequent repeat pulses; must be >= 1.
- REPEAT_EN, 1: 1 enables btn_repeat; 0 forces btn_repeat to 0.

Ports:
- clk  input  1  system clock; single clock domain, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_sync  input  1  synchronised raw button level from the synchroniser; 1 = pressed.
- btn_level  output  1  debounced button level.
- btn_press  output  1  one-cycle strobe on accepted press.
- btn_release  output  1  one-cycle strobe on accepted release.
- btn_repeat  output  1  one-cycle auto-repeat strobe while held.

Behaviour:
- All outputs are registered.
- Reset (async, asserted):
  - state = RELEASED; debounce and hold counters = 0.
  - btn_level, btn_press, btn_release, btn_repeat = 0, immediately, independent of clk.
  - Reset mid-press: outputs drop at once and no btn_release is generated.
  - After deassertion, a button still held requires a full DEBOUNCE_CYCLES qualification before a new btn_press.
- Counter widths: $clog2(max value + 1) for each counter. Counters are cleared on every state entry and never wrap.
- RELEASED state (btn_level = 0):
  - sig_sync = 1 sampled: go to PRESS_CHK, debounce count = 1.
- PRESS_CHK state:
  - sig_sync = 0 sampled: return to RELEASED (glitch rejected, no strobe).
  - Otherwise increment count.
  - On the edge where the DEBOUNCE_CYCLES-th consecutive high sample is taken: go to HELD; btn_level <= 1 and btn_press <= 1 on that same edge.
  - DEBOUNCE_CYCLES = 1 means the first high sample is accepted.
- HELD state (btn_level = 1):
  - Hold counter increments each cycle.
  - If REPEAT_EN = 1: btn_repeat pulses for one cycle HOLD_CYCLES cycles after btn_press, then every REPEAT_CYCLES cycles.
  - sig_sync = 0 sampled: go to RELEASE_CHK, debounce count = 1. The hold and repeat timers freeze; no repeat strobe is issued while in RELEASE_CHK.
- RELEASE_CHK state (btn_level stays 1):
  - sig_sync = 1 sampled: return to HELD. The hold/repeat timing restarts from 0, so the next repeat comes HOLD_CYCLES later.
  - DEBOUNCE_CYCLES-th consecutive low sample: go to RELEASED; btn_level <= 0 and btn_release <= 1 on that edge.
- Strobe rules:
  - btn_press, btn_release and btn_repeat are each high for exactly one cycle per event.
  - They are mutually exclusive in any cycle.
  - A repeat is never emitted in the same cycle as btn_press.
- Latency: btn_press/btn_release appear DEBOUNCE_CYCLES edges after the first qualifying sample of sig_sync. The synchroniser adds its own 2 cycles ahead of this.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1.
1. Glitch: sig_sync high for 3 cycles, then low -> btn_press never asserts, btn_level stays 0, FSM back in RELEASED.
2. Clean press: sig_sync high from edge 0 and held -> btn_level and btn_press go high on edge 3 (4th high sample); btn_press is low again from edge 4.
3. Auto-repeat: keep sig_sync high -> btn_repeat single-cycle pulses at 10, 13 and 16 cycles after the btn_press edge. No other strobes occur.
4. Bouncy release: from HELD, sig_sync low 2 cycles, high 1 cycle, then low 4 cycles -> btn_level stays 1 during the bounce. Exactly one btn_release on the 4th consecutive low sample, btn_level 0 from that edge, and no spurious btn_press.
5. Reset mid-hold: assert rst between clock edges while in HELD -> all outputs 0 immediately, no btn_release. Deassert rst with sig_sync still high -> btn_press appears only after 4 further high samples.
6. REPEAT_EN=0: press and hold for 50 cycles -> btn_repeat stays 0 throughout; the btn_press and btn_release strobes are unchanged.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: debounces an already-synchronised level and emits
// single-cycle press, release and typematic repeat strobes.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_sync,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT_CYCLES);

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rpt_phase_q, rpt_phase_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              repeat_q, repeat_d;

  logic [DEB_W-1:0]  deb_inc;
  logic [HOLD_W-1:0] hold_inc;
  logic [HOLD_W-1:0] hold_target;
  logic              hold_hit;

  // State and counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RELEASED;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  // Next-state and counter logic; every state entry clears the counters
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rpt_phase_d = rpt_phase_q;
    deb_inc     = deb_cnt_q + DEB_ONE;
    hold_inc    = hold_cnt_q + HOLD_ONE;
    hold_target = rpt_phase_q ? RPT_LAST : HOLD_LAST;
    hold_hit    = 1'b0;

    case (state_q)
      S_RELEASED: begin
        if (sig_sync) begin
          if (DEB_ONE == DEB_LAST) begin
            state_d     = S_HELD;
            deb_cnt_d   = '0;
            hold_cnt_d  = '0;
            rpt_phase_d = 1'b0;
          end else begin
            state_d   = S_PRESS_CHK;
            deb_cnt_d = DEB_ONE;
          end
        end
      end

      S_PRESS_CHK: begin
        if (!sig_sync) begin
          state_d   = S_RELEASED;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d     = S_HELD;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
          rpt_phase_d = 1'b0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      S_HELD: begin
        if (!sig_sync) begin
          // Hold timing freezes here and restarts on any return to HELD
          if (DEB_ONE == DEB_LAST) begin
            state_d   = S_RELEASED;
            deb_cnt_d = '0;
          end else begin
            state_d   = S_RELEASE_CHK;
            deb_cnt_d = DEB_ONE;
          end
        end else if (hold_inc == hold_target) begin
          hold_hit    = 1'b1;
          hold_cnt_d  = '0;
          rpt_phase_d = 1'b1;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end

      S_RELEASE_CHK: begin
        if (sig_sync) begin
          state_d     = S_HELD;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
          rpt_phase_d = 1'b0;
        end else if (deb_inc == DEB_LAST) begin
          state_d   = S_RELEASED;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      default: begin
        state_d     = S_RELEASED;
        deb_cnt_d   = '0;
        hold_cnt_d  = '0;
        rpt_phase_d = 1'b0;
      end
    endcase
  end

  // Output decode from the transition about to be taken
  always_comb begin
    level_d   = (state_d == S_HELD) || (state_d == S_RELEASE_CHK);
    press_d   = ((state_q == S_RELEASED) || (state_q == S_PRESS_CHK)) && (state_d == S_HELD);
    release_d = ((state_q == S_HELD) || (state_q == S_RELEASE_CHK)) && (state_d == S_RELEASED);
    repeat_d  = REPEAT_EN && hold_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule
